// File: rtl/addpipe_pkg.sv
// Shared constants and helpers for the pipelined adder and its inter-stage buffers.
package addpipe_pkg;

    localparam int ADD_WIDTH  = 32;
    localparam int PIPE_DEPTH = 3;

    // Elaboration-time ceil(log2(n)); n <= 1 yields 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One elastic pipeline slot: a valid bit plus a data register that loads only with valid data.
module pipe_slot
    import addpipe_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             flush,
    input  logic             ready,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            v <= 1'b0;
            d <= '0;
        end else if (flush) begin
            v <= 1'b0;
        end else if (ready) begin
            v <= v_in;
            if (v_in) d <= d_in;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic valid/ready register chain of DEPTH slots with combinational backward stall and bubble collapse.
// Optional occupancy counter enabled by defining PIPE_OCC_EN.
module pipe_reg_chain
    import addpipe_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int DEPTH = PIPE_DEPTH
`ifdef PIPE_OCC_EN
    , localparam int OCC_W = clog2(DEPTH + 1)
`endif
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_OCC_EN
    , output logic [OCC_W-1:0] occupancy
`endif
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("pipe_reg_chain: DEPTH must be >= 1");
    end

    logic [DEPTH:0]                rdy;
    logic [DEPTH-1:0]              v;
    logic [DEPTH-1:0]              v_in;
    logic [DEPTH-1:0][WIDTH-1:0]   d;
    logic [DEPTH-1:0][WIDTH-1:0]   d_in;

    // A slot can take new data if it is empty or its successor can take its contents.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !v[i] || rdy[i+1];
        end
    end

    assign in_ready = rdy[0] & ~flush;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == 0) begin : g_head
            assign v_in[i] = in_valid & in_ready;
            assign d_in[i] = in_data;
        end else begin : g_body
            assign v_in[i] = v[i-1];
            assign d_in[i] = d[i-1];
        end

        pipe_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .clr_n (clr_n),
            .flush (flush),
            .ready (rdy[i]),
            .v_in  (v_in[i]),
            .d_in  (d_in[i]),
            .v     (v[i]),
            .d     (d[i])
        );
    end

    // Masking with flush keeps a flush cycle free of any output transfer.
    assign out_valid = v[DEPTH-1] & ~flush;
    assign out_data  = d[DEPTH-1];

`ifdef PIPE_OCC_EN
    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain (WIDTH=32, DEPTH=3): vector table plus scoreboarded corner-case sequences.
module tb_pipe_reg_chain;

    logic        clk;
    logic        clr_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef PIPE_OCC_EN
    logic [1:0]  occupancy;
`endif

    pipe_reg_chain #(.WIDTH(32), .DEPTH(3)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_OCC_EN
        , .occupancy (occupancy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [31:0] e_occ;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] sb [$];
    int          checks   = 0;
    int          failures = 0;
    int          n_out    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_occ(input string name, input logic [31:0] exp);
`ifdef PIPE_OCC_EN
        chk(name, 32'(occupancy), exp);
`endif
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Record the transfers visible this cycle, then advance one edge.
    task automatic xfer_edge();
        logic [31:0] exp;
        if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                chk("unexpected_out", out_data, 32'hDEAD_BEEF);
            end else begin
                exp = sb.pop_front();
                chk("sb_order", out_data, exp);
            end
        end
        if (in_valid && in_ready) sb.push_back(in_data);
        if (flush) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        #2;
        xfer_edge();
    endtask

    initial begin
        int start;

        // Backpressure: 3 accepts fill the chain, D waits, then drains in order.
        tbl[0] = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'd0};
        tbl[1] = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'd1};
        tbl[2] = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'd2};
        tbl[3] = '{1'b1, 32'hD, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA, 32'd3};
        tbl[4] = '{1'b1, 32'hD, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA, 32'd3};
        tbl[5] = '{1'b1, 32'hD, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA, 32'd3};
        tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB, 32'd3};
        tbl[7] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hC, 32'd2};
        tbl[8] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hD, 32'd1};
        tbl[9] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hD, 32'd0};

        clr_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk_occ("rst_occ", 32'd0);
        clr_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            #2;
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
            chk_occ($sformatf("tbl%0d_occ", i), tbl[i].e_occ);
            xfer_edge();
        end

        // Streaming: word k+1 accepted at edge k is on the output before edge k+3.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'(k + 1), 1'b1, 1'b0);
            #2;
            chk($sformatf("stream%0d_in_ready", k), 32'(in_ready), 32'd1);
            if (k < 3) begin
                chk($sformatf("stream%0d_out_valid", k), 32'(out_valid), 32'd0);
            end else begin
                chk($sformatf("stream%0d_out_data", k), out_data, 32'(k - 2));
                chk_occ($sformatf("stream%0d_occ", k), 32'd3);
            end
            xfer_edge();
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            cycle();
        end
        chk("stream_drained", 32'(sb.size()), 32'd0);

        // Bubble collapse with the output stalled.
        drive(1'b1, 32'h5, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cycle();
        cycle();
        drive(1'b1, 32'h6, 1'b0, 1'b0);
        #2;
        chk("bubble_in_ready_stalled", 32'(in_ready), 32'd1);
        xfer_edge();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cycle();
        #2;
        chk_occ("bubble_occ", 32'd2);
        chk("bubble_in_ready", 32'(in_ready), 32'd1);
        chk("bubble_out_data", out_data, 32'h5);
        xfer_edge();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            cycle();
        end
        chk("bubble_drained", 32'(sb.size()), 32'd0);

        // Flush of a full chain: nothing emitted during or after.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h40 + 32'(k), 1'b0, 1'b0);
            cycle();
        end
        start = n_out;
        drive(1'b1, 32'h77, 1'b1, 1'b1);
        #2;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        xfer_edge();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #2;
        chk("post_flush_out_valid", 32'(out_valid), 32'd0);
        chk("post_flush_in_ready", 32'(in_ready), 32'd1);
        chk_occ("post_flush_occ", 32'd0);
        xfer_edge();
        for (int k = 0; k < 4; k++) cycle();
        chk("flush_no_output", 32'(n_out - start), 32'd0);

        // Full chain with one word in and one word out every cycle.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h100 + 32'(k), 1'b0, 1'b0);
            cycle();
        end
        start = n_out;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h200 + 32'(k), 1'b1, 1'b0);
            #2;
            chk($sformatf("simul%0d_in_ready", k), 32'(in_ready), 32'd1);
            chk_occ($sformatf("simul%0d_occ", k), 32'd3);
            xfer_edge();
        end
        chk("simul_out_count", 32'(n_out - start), 32'd10);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            cycle();
        end
        chk("simul_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset with two words in flight.
        drive(1'b1, 32'h31, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 32'h32, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cycle();
        #2;
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        chk("pre_reset_out_data", out_data, 32'h31);
        clr_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_data", out_data, 32'h0);
        chk_occ("async_rst_occ", 32'd0);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        sb.delete();
        start = n_out;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 5; k++) cycle();
        chk("post_rst_no_output", 32'(n_out - start), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
